dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 (pipeline MEM stage)
//  and port 1 (loader/debug DMA). Round-robin arbitration, one access in flight.
//  Sequences each access as grant -> memory cycle -> registered response.
//  Sits between the requesters and data_memory; drives its A/WE/WD and samples its RD.
// PARAMETERS
//  ADDR_W     32    requester/memory address width (word index, as data_memory uses A directly)
//  DATA_W     32    data width
//  MEM_DEPTH  1024  number of valid words; addr >= MEM_DEPTH is out of range
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       asynchronous, active-high reset
//  m0_req     in   1       port 0 request; hold with fields stable until m0_gnt
//  m0_we      in   1       port 0: 1=write, 0=read
//  m0_addr    in   ADDR_W  port 0 word address
//  m0_wdata   in   DATA_W  port 0 write data
//  m0_gnt     out  1       port 0 request accepted this cycle (combinational)
//  m0_rvalid  out  1       port 0 response pulse, 1 cycle
//  m0_rdata   out  DATA_W  port 0 read data, valid with m0_rvalid
//  m0_err     out  1       port 0 out-of-range flag, valid with m0_rvalid
//  m1_*       -    -       identical set for port 1
//  mem_A      out  ADDR_W  to data_memory A
//  mem_WE     out  1       to data_memory WE
//  mem_WD     out  DATA_W  to data_memory WD
//  mem_RD     in   DATA_W  from data_memory RD (combinational read)
// BEHAVIOUR
//  - FSM states: IDLE, ACCESS, RESP. Reset -> IDLE; all outputs 0; last_gnt=1 (port 0 wins 1st tie).
//  - Accepting states: IDLE and RESP. In an accepting state with any req: gnt to winner
//    (combinationally), latch {port, we, addr, wdata} at posedge, next state ACCESS.
//    No req: RESP->IDLE, IDLE stays.
//  - Arbitration: single req wins; both -> port != last_gnt; last_gnt updates on every grant.
//  - ACCESS (1 cycle): mem_A=latched addr, mem_WD=latched wdata, mem_WE=latched we & in_range.
//    Read data mem_RD captured into rdata reg at end of cycle. Write commits at that edge. -> RESP.
//  - RESP: rvalid pulses on latched port only, rdata/err held for that cycle. Write response
//    rdata=0. Out of range (addr >= MEM_DEPTH): no memory write, rdata=0, err=1.
//  - Latency: gnt in cycle N, memory cycle N+1, rvalid N+2. Throughput: 1 access / 2 cycles
//    (grant in RESP overlaps response).
//  - Outside ACCESS: mem_WE=0, mem_A=0, mem_WD=0 (no stray writes or reads).
//  - Requester dropping req before gnt: request withdrawn, no effect. Fields after gnt ignored.
//  - Reset mid-operation: async return to IDLE; mem_WE drops immediately (pending write aborted),
//    no rvalid issued for the aborted access.
//  - gnt never asserted in ACCESS; at most one of m0_gnt/m1_gnt and of m0_rvalid/m1_rvalid is high.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/ACCESS/RESP) and MEM_DEPTH default.
//  - Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], accept, last_gnt reg -> gnt[1:0]).
//  - Top: FSM, request latch, response registers, memory drive muxing.
// TESTING
//  1. Reset, m0 write addr 5 data 0xDEADBEEF, then m0 read addr 5 -> rvalid at N+2, rdata=0xDEADBEEF, err=0.
//  2. m0_req and m1_req both held from reset -> grants alternate m0,m1,m0,m1 every 2 cycles.
//  3. m1 read addr 1024 (MEM_DEPTH) -> m1_rvalid with err=1, rdata=0; mem_WE never high.
//  4. m1 write addr 1023 0x1C, m0 read 1023 next grant -> m0_rdata=0x0000001C.
//  5. Assert rst during ACCESS of write to addr 7 -> mem_WE low same cycle, no rvalid, word 7 unchanged.
//  6. Continuous m0 reads, addr 0..9 -> one rvalid every 2 cycles, m1 ports silent, no gnt in ACCESS.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default sizes.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MEM_DEPTH_DEF = 1024;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the port not granted last.
// Latency: combinational grant; the priority pointer moves at the clock edge after each grant.
// Backpressure: no grant at all while accept_i is low.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // Last granted port; reset to 1 so port 0 wins the first tie.
    logic last_gnt_q, last_gnt_d;

    // Grant selection and priority pointer update.
    always_comb begin
        gnt_o      = 2'b00;
        last_gnt_d = last_gnt_q;
        if (accept_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        if (|gnt_o) begin
            last_gnt_d = gnt_o[1];
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between two requesters, one access in flight at a time.
// Latency: gnt in cycle N, memory cycle N+1, registered response (rvalid) in N+2.
// Backpressure: requesters hold req until gnt; no grant during the memory cycle (1 access / 2 cycles).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_WD,
    input  logic [DATA_W-1:0] mem_RD
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [1:0]        req, gnt;
    logic              accept, in_range;
    logic              port_q, we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    assign req      = {m1_req, m0_req};
    // Grants only in IDLE/RESP; forcing them low in reset keeps every output quiet.
    assign accept   = (state_q != ST_ACCESS) && !rst;
    assign in_range = addr_q < DEPTH_A;
    assign m0_gnt   = gnt[0];
    assign m1_gnt   = gnt[1];

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Next state, memory drive and response outputs; memory lines stay at zero outside ACCESS.
    always_comb begin
        state_d   = state_q;
        mem_A     = '0;
        mem_WE    = 1'b0;
        mem_WD    = '0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_A   = addr_q;
                mem_WD  = wdata_q;
                mem_WE  = we_q & in_range;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = (|gnt) ? ST_ACCESS : ST_IDLE;
                if (port_q) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = rdata_q;
                    m1_err    = err_q;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = rdata_q;
                    m0_err    = err_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request; fields presented after the grant are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (|gnt) begin
            port_q  <= gnt[1];
            we_q    <= gnt[1] ? m1_we    : m0_we;
            addr_q  <= gnt[1] ? m1_addr  : m0_addr;
            wdata_q <= gnt[1] ? m1_wdata : m0_wdata;
        end
    end

    // Response registers loaded at the end of the memory cycle; writes and out-of-range give zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            rdata_q <= (we_q || !in_range) ? '0 : mem_RD;
            err_q   <= !in_range;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a behavioural memory and reference model.
// Latency: expects rvalid two cycles after each observed grant.
// Backpressure: requesters hold req until granted, or withdraw it before a grant.
module tb_dmem_arbiter;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural single-port memory with combinational read.
    logic [31:0] dmem [0:DEPTH-1];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (mem_WE && mem_A < DEPTH) begin
            dmem[mem_A[9:0]] <= mem_WD;
        end
    end
    assign mem_RD = (mem_A < DEPTH) ? dmem[mem_A[9:0]] : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: words written so far, otherwise the initial pattern.
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(int'(a));
    endfunction

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    // Issue tracker: predicts grants and the memory bus, pushes expected responses.
    bit          exp_access = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_a = '0, exp_wd = '0;
    int          last_p = 1;
    bit          pend_vld = 1'b0;
    int          pend_due = 0;
    logic [31:0] pend_a = '0, pend_d = '0;

    always @(negedge clk) begin
        logic [1:0]  eg;
        int          p;
        logic        we, inr;
        logic [31:0] a, d;
        exp_t        e;
        if (rst) begin
            chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
            chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            chk("rst_memwe", 32'(mem_WE), 32'd0);
            exp_access = 1'b0;
            last_p     = 1;
            pend_vld   = 1'b0;
        end else begin
            if (pend_vld && cyc >= pend_due) begin
                ref_mem[pend_a] = pend_d;
                pend_vld = 1'b0;
            end
            chk("mem_WE", 32'(mem_WE), exp_access ? 32'(exp_we) : 32'd0);
            chk("mem_A", mem_A, exp_access ? exp_a : 32'd0);
            chk("mem_WD", mem_WD, exp_access ? exp_wd : 32'd0);
            eg = 2'b00;
            if (!exp_access) begin
                if (m0_req && m1_req) eg = (last_p == 1) ? 2'b01 : 2'b10;
                else if (m0_req)      eg = 2'b01;
                else if (m1_req)      eg = 2'b10;
            end
            chk("gnt", 32'({m1_gnt, m0_gnt}), 32'(eg));
            if (m0_gnt ^ m1_gnt) begin
                p   = m1_gnt ? 1 : 0;
                we  = p ? m1_we : m0_we;
                a   = p ? m1_addr : m0_addr;
                d   = p ? m1_wdata : m0_wdata;
                inr = a < DEPTH;
                e.port  = p;
                e.rdata = (we || !inr) ? 32'h0 : ref_rd(a);
                e.err   = !inr;
                e.due   = cyc + 2;
                sb_q.push_back(e);
                if (we && inr) begin
                    pend_vld = 1'b1;
                    pend_due = cyc + 2;
                    pend_a   = a;
                    pend_d   = d;
                end
                last_p     = p;
                exp_access = 1'b1;
                exp_we     = we && inr;
                exp_a      = a;
                exp_wd     = d;
            end else begin
                exp_access = 1'b0;
            end
        end
    end

    // Response monitor: pops and compares whenever a response appears.
    always @(negedge clk) begin
        exp_t e;
        int   rp;
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("rvalid_onehot", 32'(m0_rvalid && m1_rvalid), 32'd0);
            if (m0_rvalid || m1_rvalid) begin
                rp = m1_rvalid ? 1 : 0;
                if (sb_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_port", 32'(rp), 32'(e.port));
                    chk("resp_rdata", rp ? m1_rdata : m0_rdata, e.rdata);
                    chk("resp_err", 32'(rp ? m1_err : m0_err), 32'(e.err));
                    chk("resp_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                chk("rvalid_missing", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic drive(input int p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Request and hold until granted; call just after a rising edge, returns just after one.
    task automatic do_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic got = 1'b0;
        int   n = 0;
        drive(p, 1'b1, we, a, d);
        while (!got && n < 50) begin
            @(negedge clk);
            got = p ? m1_gnt : m0_gnt;
            n++;
        end
        chk("gnt_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Request for one cycle only, withdrawing it if not granted.
    task automatic try_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic got;
        drive(p, 1'b1, we, a, d);
        @(negedge clk);
        got = p ? m1_gnt : m0_gnt;
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic port_loop(input int p);
        logic [31:0] a;
        logic        we;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
            a  = ($urandom_range(0, 7) == 0) ? 32'(1020 + $urandom_range(0, 7))
                                             : 32'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) try_req(p, we, a, $urandom);
            else                           do_req(p, we, a, $urandom);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back on port 0.
        do_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
        do_req(0, 1'b0, 32'd5, 32'h0);

        // Both ports requesting back to back: grants alternate.
        fork
            begin do_req(0, 1'b0, 32'd2, 32'h0); do_req(0, 1'b0, 32'd3, 32'h0); end
            begin do_req(1, 1'b0, 32'd4, 32'h0); do_req(1, 1'b0, 32'd6, 32'h0); end
        join

        // Out-of-range read and write on port 1.
        do_req(1, 1'b0, 32'd1024, 32'h0);
        do_req(1, 1'b1, 32'd1024, 32'h12345678);

        // Last valid word written by port 1, read by port 0.
        do_req(1, 1'b1, 32'd1023, 32'h0000001C);
        do_req(0, 1'b0, 32'd1023, 32'h0);

        // Reset during the memory cycle of a write to word 7.
        do_req(0, 1'b1, 32'd7, 32'hCAFEF00D);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_memwe", 32'(mem_WE), 32'd0);
        chk("abort_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("word7_kept", dmem[7], init_val(7));

        // Streaming reads on port 0.
        for (int i = 0; i < 10; i++) do_req(0, 1'b0, 32'(i), 32'h0);

        // Randomised traffic from both ports.
        fork
            port_loop(0);
            port_loop(1);
        join

        repeat (6) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
